// File: rtl/line_pkg.sv
// Shared types and constants for the Bresenham line-drawing core.
package line_pkg;

  localparam int COORD_W = 13;

  // The doubled error term needs two bits of headroom over a coordinate.
  function automatic int err_width(input int coord_w);
    return coord_w + 2;
  endfunction

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SETUP = 2'd1;
  localparam logic [STATE_W-1:0] ST_STEP  = 2'd2;

  localparam logic signed [1:0] STEP_POS = 2'sb01;
  localparam logic signed [1:0] STEP_NEG = 2'sb11;

endpackage

// File: rtl/line_err_update.sv
// Combinational Bresenham error update: decides the x/y steps from the
// pre-update error and returns the error after both steps are applied.
module line_err_update
  import line_pkg::*;
#(
  parameter int ERR_W = err_width(COORD_W)
) (
  input  logic signed [ERR_W-1:0] err,
  input  logic signed [ERR_W-1:0] dx,
  input  logic signed [ERR_W-1:0] dy,
  output logic signed [ERR_W-1:0] err_next,
  output logic                    x_step,
  output logic                    y_step
);

  logic signed [ERR_W-1:0] e2;

  always_comb begin
    e2       = {err[ERR_W-2:0], 1'b0};
    x_step   = (e2 >= dy);
    y_step   = (e2 <= dx);
    err_next = err;
    if (x_step) err_next = err_next + dy;
    if (y_step) err_next = err_next + dx;
  end

endmodule

// File: rtl/line_stepper.sv
// Bresenham line rasteriser: accepts two signed endpoints and emits one pixel
// per downstream handshake. Define LINE_STEPPER_ABORT_EN to add an abort input.
module line_stepper
  import line_pkg::*;
#(
  parameter int WIDTH = COORD_W,
  parameter int ERR_W = err_width(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] x1,
  input  logic signed [WIDTH-1:0] y1,
`ifdef LINE_STEPPER_ABORT_EN
  input  logic                    abort,
`endif
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic signed [WIDTH-1:0] pix_x,
  output logic signed [WIDTH-1:0] pix_y,
  output logic                    pix_last,
  output logic                    busy
);

  logic [STATE_W-1:0]      state;
  logic signed [WIDTH-1:0] x_start, y_start, x_end, y_end;
  logic signed [WIDTH-1:0] dx, dy;
  logic signed [1:0]       sx, sy;
  logic signed [ERR_W-1:0] err, err_next;
  logic                    x_step, y_step;
  logic                    abort_req;

  // Differences are taken one bit wider so the sign survives before the
  // magnitude is trimmed back to WIDTH bits.
  logic signed [WIDTH:0]   diff_x, diff_y, abs_x, abs_y;
  logic signed [WIDTH-1:0] setup_dx, setup_dy;

  always_comb begin
    diff_x   = {x_end[WIDTH-1], x_end} - {x_start[WIDTH-1], x_start};
    diff_y   = {y_end[WIDTH-1], y_end} - {y_start[WIDTH-1], y_start};
    abs_x    = diff_x[WIDTH] ? -diff_x : diff_x;
    abs_y    = diff_y[WIDTH] ? -diff_y : diff_y;
    setup_dx = abs_x[WIDTH-1:0];
    setup_dy = -abs_y[WIDTH-1:0];
  end

`ifdef LINE_STEPPER_ABORT_EN
  assign abort_req = abort && (state != ST_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign pix_valid   = (state == ST_STEP);
  assign pix_last    = (state == ST_STEP) && (pix_x == x_end) && (pix_y == y_end);

  line_err_update #(
    .ERR_W(ERR_W)
  ) u_err_update (
    .err      (err),
    .dx       (ERR_W'(dx)),
    .dy       (ERR_W'(dy)),
    .err_next (err_next),
    .x_step   (x_step),
    .y_step   (y_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      x_start <= '0;
      y_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
      dx      <= '0;
      dy      <= '0;
      sx      <= STEP_POS;
      sy      <= STEP_POS;
      err     <= '0;
      pix_x   <= '0;
      pix_y   <= '0;
    end else if (abort_req) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            x_start <= x0;
            y_start <= y0;
            x_end   <= x1;
            y_end   <= y1;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          dx    <= setup_dx;
          dy    <= setup_dy;
          sx    <= diff_x[WIDTH] ? STEP_NEG : STEP_POS;
          sy    <= diff_y[WIDTH] ? STEP_NEG : STEP_POS;
          err   <= ERR_W'(setup_dx) + ERR_W'(setup_dy);
          pix_x <= x_start;
          pix_y <= y_start;
          state <= ST_STEP;
        end
        ST_STEP: begin
          if (pix_ready) begin
            if (pix_last) begin
              state <= ST_IDLE;
            end else begin
              err <= err_next;
              if (x_step) pix_x <= pix_x + WIDTH'(sx);
              if (y_step) pix_y <= pix_y + WIDTH'(sy);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_stepper.sv
// Scoreboard testbench for line_stepper: a reference Bresenham model queues
// the expected pixels, a monitor pops and compares them on every handshake.
module tb_line_stepper;
  import line_pkg::*;

  localparam int W = COORD_W;

  typedef struct {
    int x;
    int y;
    int last;
  } pix_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start_valid = 1'b0;
  logic                start_ready;
  logic signed [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
`ifdef LINE_STEPPER_ABORT_EN
  logic                abort = 1'b0;
`endif
  logic                pix_valid;
  logic                pix_ready = 1'b1;
  logic signed [W-1:0] pix_x, pix_y;
  logic                pix_last;
  logic                busy;

  pix_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pix_count = 0;
  int   expected_count = 0;

  always #5 clk = ~clk;

  line_stepper #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
`ifdef LINE_STEPPER_ABORT_EN
    .abort       (abort),
`endif
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_last    (pix_last),
    .busy        (busy)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Textbook integer Bresenham, one queue entry per emitted pixel.
  function automatic void modelLine(input int ax0, input int ay0, input int ax1, input int ay1);
    int dxm, dym, sxm, sym, errm, e2, xm, ym, guard;
    dxm  = iabs(ax1 - ax0);
    dym  = -iabs(ay1 - ay0);
    sxm  = (ax1 >= ax0) ? 1 : -1;
    sym  = (ay1 >= ay0) ? 1 : -1;
    errm = dxm + dym;
    xm   = ax0;
    ym   = ay0;
    for (guard = 0; guard < 4096; guard++) begin
      sb.push_back('{x: xm, y: ym, last: int'(xm == ax1 && ym == ay1)});
      if (xm == ax1 && ym == ay1) break;
      e2 = 2 * errm;
      if (e2 >= dym) begin errm += dym; xm += sxm; end
      if (e2 <= dxm) begin errm += dxm; ym += sym; end
    end
  endfunction

  always @(negedge clk) begin
    pix_t e;
    if (rst_n && pix_valid === 1'b1 && pix_ready === 1'b1) begin
      pix_count++;
      if (sb.size() == 0) begin
        checkOutput("extra_pixel", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("pix_x", int'(pix_x), e.x);
        checkOutput("pix_y", int'(pix_y), e.y);
        checkOutput("pix_last", int'(pix_last), e.last);
      end
    end
  end

  // Called #1 after a rising edge; returns once the first pixel is visible.
  task automatic applyStimulus(input int ax0, input int ay0, input int ax1, input int ay1);
    int n, lat, adx, ady;
    n = 0;
    while (start_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("start_ready", int'(start_ready), 1);
    adx = iabs(ax1 - ax0);
    ady = iabs(ay1 - ay0);
    expected_count = ((adx > ady) ? adx : ady) + 1;
    pix_count = 0;
    modelLine(ax0, ay0, ax1, ay1);
    x0 = W'(ax0); y0 = W'(ay0); x1 = W'(ax1); y1 = W'(ay1);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    x0 = W'($urandom); y0 = W'($urandom); x1 = W'($urandom); y1 = W'($urandom);
    checkOutput("busy_setup", int'(busy), 1);
    lat = 1;
    while (pix_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    checkOutput("first_latency", lat, 2);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (start_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("done_timeout", int'(start_ready), 1);
    checkOutput("busy_idle", int'(busy), 0);
    checkOutput("drained", sb.size(), 0);
    checkOutput("pix_count", pix_count, expected_count);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_start_ready", int'(start_ready), 1);
    checkOutput("rst_pix_valid", int'(pix_valid), 0);
    checkOutput("rst_pix_last", int'(pix_last), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_pix_x", int'(pix_x), 0);
    checkOutput("rst_pix_y", int'(pix_y), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] shallow line (0,0)->(5,2)");
    applyStimulus(0, 0, 5, 2);
    waitDone();

    $display("[TB] reverse diagonal (3,3)->(0,0)");
    applyStimulus(3, 3, 0, 0);
    waitDone();

    $display("[TB] degenerate line (7,-3)");
    applyStimulus(7, -3, 7, -3);
    checkOutput("degen_last", int'(pix_last), 1);
    @(posedge clk); #1;
    checkOutput("b2b_ready", int'(start_ready), 1);
    waitDone();

    $display("[TB] backpressure on third pixel");
    applyStimulus(0, 0, 5, 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pix_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("hold_valid", int'(pix_valid), 1);
      checkOutput("hold_x", int'(pix_x), 2);
      checkOutput("hold_y", int'(pix_y), 1);
      checkOutput("hold_last", int'(pix_last), 0);
      @(posedge clk); #1;
    end
    pix_ready = 1'b1;
    waitDone();

    $display("[TB] steep line with mixed signs");
    applyStimulus(-4, 2, -1, -7);
    waitDone();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 60)) - 30,
                    int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 60)) - 30);
      waitDone();
    end

    $display("[TB] reset during second pixel");
    applyStimulus(0, 0, 0, 6);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", int'(pix_valid), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_ready", int'(start_ready), 1);
    checkOutput("mid_rst_x", int'(pix_x), 0);
    checkOutput("mid_rst_y", int'(pix_y), 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1, 1, 2, 1);
    waitDone();

`ifdef LINE_STEPPER_ABORT_EN
    $display("[TB] abort during second pixel");
    applyStimulus(0, 0, 10, 0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_valid", int'(pix_valid), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_ready", int'(start_ready), 1);
    sb.delete();
    applyStimulus(2, 2, 4, 3);
    waitDone();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
